// File: rtl/counter_flop.sv
// counter_flop: one BCD digit of a chained seconds/ns counter plus its
// 8x16 seven-segment glyph renderer for a pixel-scanning display.
// A base stage (COUNT_SIZE=20) advances whenever the free-running ns tick
// count reaches 999999. A cascaded stage (COUNT_SIZE=4) advances when the
// previous digit is 9 and the global tick is at 999999. That is the same
// edge on which the previous stage wraps 9->0.
module counter_flop #(
    parameter logic [10:0] X_BOX      = 11'd820,
    parameter logic [9:0]  Y_BOX      = 10'd72,
    parameter logic [4:0]  COUNT_SIZE = 5'd20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COUNT_SIZE-1:0] count_enable_in,
    input  logic [19:0]           time_ns,
    input  logic [10:0]           x,
    input  logic [9:0]            y,
    output logic [3:0]            count_enable_out,
    output logic                  pixel_on
);

    localparam logic [19:0] TICK_LAST = 20'd999999;

    logic       inc;
    logic [3:0] digit;

    // Increment qualifier: its source depends on the position in the chain.
    generate
        if (COUNT_SIZE == 5'd20) begin : g_base
            // The base stage reads its own tick input. The global tick is not needed here.
            logic unused_time_ns;
            assign unused_time_ns = ^time_ns;
            assign inc = (count_enable_in == TICK_LAST);
        end else begin : g_cascade
            assign inc = (count_enable_in[3:0] == 4'd9) && (time_ns == TICK_LAST);
        end
    endgenerate

    // Digit register: async clear, wraps 9->0, and recovers from 10..15 to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit <= 4'd0;
        end else if (inc) begin
            digit <= (digit >= 4'd9) ? 4'd0 : digit + 4'd1;
        end
    end

    assign count_enable_out = digit;

    // Glyph box geometry. The values are widened to 12 bits so that the far edges cannot wrap.
    logic [11:0] x_ext;
    logic [11:0] y_ext;
    logic [11:0] x_lo;
    logic [11:0] y_lo;
    logic [11:0] lx;
    logic [11:0] ly;
    logic        in_box;

    assign x_ext = {1'b0, x};
    assign y_ext = {2'b00, y};
    assign x_lo  = {1'b0, X_BOX};
    assign y_lo  = {2'b00, Y_BOX};
    assign lx    = x_ext - x_lo;
    assign ly    = y_ext - y_lo;

    // Box test: 8 columns by 16 rows from the (X_BOX, Y_BOX) corner.
    always_comb begin
        in_box = (x_ext >= x_lo) && (x_ext < x_lo + 12'd8) &&
                 (y_ext >= y_lo) && (y_ext < y_lo + 12'd16);
    end

    // Segment lit mask for the current digit, bit order {a,b,c,d,e,f,g}.
    logic [6:0] seg_lit;

    always_comb begin
        seg_lit = 7'b0000000;
        case (digit)
            4'd0:    seg_lit = 7'b1111110;
            4'd1:    seg_lit = 7'b0110000;
            4'd2:    seg_lit = 7'b1101101;
            4'd3:    seg_lit = 7'b1111001;
            4'd4:    seg_lit = 7'b0110011;
            4'd5:    seg_lit = 7'b1011011;
            4'd6:    seg_lit = 7'b1011111;
            4'd7:    seg_lit = 7'b1110000;
            4'd8:    seg_lit = 7'b1111111;
            4'd9:    seg_lit = 7'b1111011;
            default: seg_lit = 7'b0000000;
        endcase
    end

    // Segment regions in box-local coordinates. The segments overlap at the corners.
    logic [6:0] seg_hit;

    always_comb begin
        seg_hit    = 7'b0000000;
        // a: top bar
        seg_hit[6] = (ly <= 12'd1) && (lx >= 12'd1) && (lx <= 12'd6);
        // b: upper right
        seg_hit[5] = (lx >= 12'd6) && (lx <= 12'd7) && (ly <= 12'd8);
        // c: lower right
        seg_hit[4] = (lx >= 12'd6) && (lx <= 12'd7) && (ly >= 12'd7) && (ly <= 12'd15);
        // d: bottom bar
        seg_hit[3] = (ly >= 12'd14) && (ly <= 12'd15) && (lx >= 12'd1) && (lx <= 12'd6);
        // e: lower left
        seg_hit[2] = (lx <= 12'd1) && (ly >= 12'd7) && (ly <= 12'd15);
        // f: upper left
        seg_hit[1] = (lx <= 12'd1) && (ly <= 12'd8);
        // g: middle bar
        seg_hit[0] = (ly >= 12'd7) && (ly <= 12'd8) && (lx >= 12'd1) && (lx <= 12'd6);
    end

    // Pixel output: lit when inside the box and on any lit segment.
    always_comb begin
        pixel_on = in_box && ((seg_hit & seg_lit) != 7'b0000000);
    end

endmodule

// File: tb/tb_counter_flop.sv
// Directed bench for counter_flop: a base stage chained into a cascaded
// digit stage, with a shared tick that also feeds the cascaded time_ns.
module tb_counter_flop;

    logic        clk;
    logic        rst;
    logic [19:0] tick;
    logic [10:0] x;
    logic [9:0]  y;
    logic [3:0]  base_digit;
    logic [3:0]  stage_digit;
    logic        base_pix;
    logic        stage_pix;

    int n_checks = 0;
    int n_pass   = 0;

    counter_flop #(.COUNT_SIZE(5'd20)) u_base (
        .clk              (clk),
        .rst              (rst),
        .count_enable_in  (tick),
        .time_ns          (tick),
        .x                (x),
        .y                (y),
        .count_enable_out (base_digit),
        .pixel_on         (base_pix)
    );

    counter_flop #(.COUNT_SIZE(5'd4)) u_stage (
        .clk              (clk),
        .rst              (rst),
        .count_enable_in  (base_digit),
        .time_ns          (tick),
        .x                (x),
        .y                (y),
        .count_enable_out (stage_digit),
        .pixel_on         (stage_pix)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver: advance one edge, settle 1 ns past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick_once();
        tick = 20'd999999;
        step();
        tick = 20'd0;
    endtask

    initial begin
        rst  = 1'b0;
        tick = 20'd0;
        x    = 11'd820;
        y    = 10'd72;
        #2;
        check("reset_base", base_digit, 0);
        check("reset_stage", stage_digit, 0);
        // digit 0 lights f at the top-left corner even while held in reset
        check("reset_pix_d0", base_pix, 1);

        // increments ignored while in reset
        tick = 20'd999999;
        step();
        check("reset_ignores_inc", base_digit, 0);
        tick = 20'd0;
        rst  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_reset_idle", base_digit, 0);
        end

        // ten single-edge ticks: 1..9,0; the stage advances on the wrap edge
        for (int i = 1; i <= 10; i++) begin
            tick_once();
            check("base_step", base_digit, i % 10);
            if (i == 1) begin
                x = 11'd827; y = 10'd72;
                #1 check("pix_d1_b", base_pix, 1);
                x = 11'd820; y = 10'd72;
                #1 check("pix_d1_corner", base_pix, 0);
                x = 11'd828; y = 10'd72;
                #1 check("pix_right_out", base_pix, 0);
                x = 11'd820; y = 10'd88;
                #1 check("pix_below_out", base_pix, 0);
            end
            if (i == 8) begin
                x = 11'd822; y = 10'd79;
                #1 check("pix_d8_g", base_pix, 1);
            end
            if (i == 9) check("stage_before_wrap", stage_digit, 0);
        end
        check("stage_after_wrap", stage_digit, 1);
        // base is 0 again: the middle bar is dark, while the stage (1) is dark at this column too
        #1 check("pix_d0_no_g", base_pix, 0);

        // non-terminal tick values do nothing
        tick = 20'd999998;
        step();
        check("hold_999998", base_digit, 0);
        tick = 20'd0;
        step();
        check("hold_0", base_digit, 0);

        // held high for 3 edges increments 3 times
        tick = 20'd999999;
        step(); step(); step();
        tick = 20'd0;
        check("held_three", base_digit, 3);
        check("stage_unmoved", stage_digit, 1);

        // async reset mid-count at 7
        for (int i = 0; i < 4; i++) tick_once();
        check("at_seven", base_digit, 7);
        #3 rst = 1'b0;
        #1 check("async_clear_base", base_digit, 0);
        check("async_clear_stage", stage_digit, 0);
        #1 rst = 1'b1;
        tick_once();
        check("resume_from_0", base_digit, 1);

        // base at 9 but tick not terminal: the stage holds
        for (int i = 0; i < 8; i++) tick_once();
        check("base_at_nine", base_digit, 9);
        tick = 20'd123456;
        step(); step();
        check("stage_holds", stage_digit, 0);
        check("base_holds_nine", base_digit, 9);
        tick = 20'd0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_flop.md
COUNTER_FLOP -- requirements
Module: counter_flop

Interface
REQ-001 Parameter X_BOX, 11 bits, default 820: left pixel column of the digit glyph box.
REQ-002 Parameter Y_BOX, 10 bits, default 72: top pixel row of the digit glyph box.
REQ-003 Parameter COUNT_SIZE, 5 bits, default 20: width of count_enable_in; legal values are 20 (base stage) and 4 (cascaded digit stage).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous reset, active-low.
REQ-006 count_enable_in  input  COUNT_SIZE  base stage: free-running ns tick count; cascaded stage: previous stage's digit.
REQ-007 time_ns  input  20  global ns tick count (0..999999), used only by cascaded stages.
REQ-008 x  input  11  current pixel column.
REQ-009 y  input  10  current pixel row.
REQ-010 count_enable_out  output  4  registered BCD digit 0..9; chains into the next stage's count_enable_in.
REQ-011 pixel_on  output  1  high when (x,y) lies on a lit pixel of the current digit's glyph.

Function
REQ-012 The block SHALL hold one 4-bit digit register driving count_enable_out directly.
REQ-013 With COUNT_SIZE==20, the block SHALL compute inc = (count_enable_in == 999999); time_ns SHALL be ignored.
REQ-014 With COUNT_SIZE!=20, the block SHALL compute inc = (count_enable_in[3:0] == 9) AND (time_ns == 999999).
REQ-015 At each rising clk edge with inc=1, the digit SHALL become digit+1 if digit<9, else 0 (wrap 9->0).
REQ-016 At each rising clk edge with inc=0, the digit SHALL hold.
REQ-017 Latency: count_enable_out SHALL change on the first rising edge at which inc is sampled high; one increment per edge with inc=1, with no edge detection, so holding inc high for N edges increments N times.
REQ-018 The digit register SHALL never hold 10..15; if it does, the next increment SHALL load 0.
REQ-019 pixel_on SHALL be combinational from x, y and the digit register, with no clock latency.
REQ-020 The glyph box is 8 columns by 16 rows. lx = x-X_BOX and ly = y-Y_BOX; pixel_on SHALL be 0 outside X_BOX<=x<X_BOX+8, Y_BOX<=y<Y_BOX+16.
REQ-021 Inside the box, pixel_on SHALL be the OR of the lit segments of the digit. Segments: a: ly 0-1, lx 1-6; b: lx 6-7, ly 0-8; c: lx 6-7, ly 7-15; d: ly 14-15, lx 1-6; e: lx 0-1, ly 7-15; f: lx 0-1, ly 0-8; g: ly 7-8, lx 1-6.
REQ-022 Digit-to-segment map: 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg.
REQ-023 Box comparisons SHALL use at least 12-bit unsigned arithmetic so that X_BOX+8 and Y_BOX+16 do not overflow.
REQ-024 Cascading: a digit stage (COUNT_SIZE=4) fed by a base stage's count_enable_out SHALL increment on the same edge on which the base stage wraps 9->0.

Reset
REQ-025 When rst is low, the digit register SHALL clear to 0 immediately, independent of clk, so count_enable_out=0.
REQ-026 While rst is low, the digit SHALL ignore inc; pixel_on SHALL continue to show digit 0's glyph.
REQ-027 Reset asserted mid-count SHALL discard the current digit; after rst rises, counting resumes from 0 on the next qualifying edge.

Verification
REQ-028 Reset: rst=0, then rst=1 with count_enable_in=0 for 5 edges -> count_enable_out=0 throughout.
REQ-029 Base stage: count_enable_in=999999 held for exactly one edge, repeated 10 times -> count_enable_out steps 1,2,...,9,0; values other than 999999 (e.g. 999998, 0) -> no change.
REQ-030 Cascade: base stage chained into a 4-bit stage, with time_ns tied to the base stage's input; run 10 base increments -> base stage = 0 and digit stage = 1 after the 10th edge; base stage = 9 with time_ns != 999999 -> digit stage holds.
REQ-031 Async reset mid-count: digit=7, drive rst low between edges -> count_enable_out=0 before the next clk edge.
REQ-032 Pixel, defaults 820/72: digit 1 -> pixel_on=1 at (827,72) and 0 at (820,72); digit 8 -> 1 at (822,79); any digit -> 0 at (828,72) and (820,88).
